// File: rtl/demo_state_ctrl_if.sv
// Button/tick inputs and sprite pose/position outputs of the
// per-player animation and motion controller.
interface demo_state_ctrl_if;
    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_attack;
    logic [3:0] currentstate;
    logic [9:0] posx;
    logic [9:0] posy;
    logic       attack_active;

    modport master (
        output frame_tick, btn_left, btn_right, btn_attack,
        input  currentstate, posx, posy, attack_active
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_attack,
        output currentstate, posx, posy, attack_active
    );
endinterface

// File: rtl/demo_state_ctrl.sv
// Per-player animation state and sprite origin, updated only on
// frame ticks so pose and position never change mid-frame.
module demo_state_ctrl #(
    parameter int START_X          = 100,
    parameter int START_Y          = 200,
    parameter int X_MIN            = 0,
    parameter int X_MAX            = 490,
    parameter int FWD_STEP         = 4,
    parameter int BWD_STEP         = 3,
    parameter int ATK_START_FRAMES = 6,
    parameter int ATK_END_FRAMES   = 8,
    parameter int ATK_PULL_FRAMES  = 6
) (
    input  logic             clk,
    input  logic             rst,
    demo_state_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FORWARD   = 4'd1,
        BACKWARD  = 4'd2,
        ATK_START = 4'd3,
        ATK_END   = 4'd4,
        ATK_PULL  = 4'd5
    } state_t;

    state_t      state_q;
    state_t      state_n;
    logic [5:0]  cnt_q;
    logic [5:0]  cnt_n;
    logic        armed_q;
    logic        armed_n;
    logic        active_q;
    logic [9:0]  posx_q;
    logic [9:0]  posx_n;
    logic [10:0] fwd_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            armed_q  <= 1'b1;
            active_q <= 1'b0;
            posx_q   <= 10'(START_X);
        end else if (bus.frame_tick) begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            armed_q  <= armed_n;
            // registered with the state so hit frames line up exactly
            active_q <= (state_n == ATK_END);
            posx_q   <= posx_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q + 6'd1;
        armed_n = armed_q | ~bus.btn_attack;
        case (state_q)
            IDLE, FORWARD, BACKWARD: begin
                cnt_n = '0;
                if (bus.btn_attack && armed_q) begin
                    state_n = ATK_START;
                    armed_n = 1'b0;
                end else if (bus.btn_right && !bus.btn_left) begin
                    state_n = FORWARD;
                end else if (bus.btn_left && !bus.btn_right) begin
                    state_n = BACKWARD;
                end else begin
                    state_n = IDLE;
                end
            end
            ATK_START: begin
                if (cnt_q == 6'(ATK_START_FRAMES - 1)) begin
                    state_n = ATK_END;
                    cnt_n   = '0;
                end
            end
            ATK_END: begin
                if (cnt_q == 6'(ATK_END_FRAMES - 1)) begin
                    state_n = ATK_PULL;
                    cnt_n   = '0;
                end
            end
            ATK_PULL: begin
                if (cnt_q == 6'(ATK_PULL_FRAMES - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // 11-bit arithmetic keeps the clamps free of 10-bit wrap
    always_comb begin
        fwd_sum = {1'b0, posx_q} + 11'(FWD_STEP);
        posx_n  = posx_q;
        case (state_q)
            FORWARD: begin
                if (fwd_sum > 11'(X_MAX)) begin
                    posx_n = 10'(X_MAX);
                end else begin
                    posx_n = fwd_sum[9:0];
                end
            end
            BACKWARD: begin
                if ({1'b0, posx_q} < 11'(X_MIN + BWD_STEP)) begin
                    posx_n = 10'(X_MIN);
                end else begin
                    posx_n = posx_q - 10'(BWD_STEP);
                end
            end
            default: begin
                posx_n = posx_q;
            end
        endcase
    end

    assign bus.currentstate  = state_q;
    assign bus.posx          = posx_q;
    assign bus.posy          = 10'(START_Y);
    assign bus.attack_active = active_q;

endmodule

// File: doc/demo_state_ctrl.md
# demo_state_ctrl

Per-player animation and motion controller that sits directly upstream of the sprite ROM stage. It turns debounced button levels into an animation state code (`currentstate`) and a sprite origin (`posx`, `posy`). The ROM stage uses these to select a sprite bank and to compute pixel addresses. All state and position updates happen only on a per-frame tick, so the sprite never changes pose or position in the middle of a scanned frame.

## Interface
- `START_X`, 100: `posx` after reset.
- `START_Y`, 200: `posy` after reset; constant thereafter.
- `X_MIN`, 0: lowest legal `posx`.
- `X_MAX`, 490: highest legal `posx` (640 − 150 sprite width).
- `FWD_STEP`, 4: pixels added per frame in FORWARD.
- `BWD_STEP`, 3: pixels subtracted per frame in BACKWARD.
- `ATK_START_FRAMES`, 6: frames spent in ATTACK_START; legal range 1..63.
- `ATK_END_FRAMES`, 8: frames spent in ATTACK_END; legal range 1..63.
- `ATK_PULL_FRAMES`, 6: frames spent in ATTACK_PULL; legal range 1..63.

Ports:
- `clk`  in  1  system/pixel clock.
- `rst`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse per video frame (end of active area).
- `btn_left`  in  1  level, already synchronised and debounced.
- `btn_right`  in  1  level, already synchronised and debounced.
- `btn_attack`  in  1  level, already synchronised and debounced.
- `currentstate`  out  4  0 IDLE, 1 FORWARD, 2 BACKWARD, 3 ATTACK_START, 4 ATTACK_END, 5 ATTACK_PULL.
- `posx`  out  10  sprite left edge, in pixels.
- `posy`  out  10  sprite top edge, in pixels.
- `attack_active`  out  1  high while `currentstate` == 4 (hit frames), for downstream collision.

## Operation
- All state is held in registers. Nothing changes on a clock edge where `frame_tick` = 0.
- Internal registers:
  - 6-bit `frame_cnt`, cleared to 0 on every state change.
  - 1-bit `atk_armed`.
- On each `frame_tick`, the next state is computed from the current state.
- From IDLE, FORWARD or BACKWARD, evaluated in priority order:
  - `btn_attack` && `atk_armed` → ATTACK_START, and clear `atk_armed`.
  - else `btn_right` && !`btn_left` → FORWARD.
  - else `btn_left` && !`btn_right` → BACKWARD.
  - else → IDLE. Both direction buttons or neither selects IDLE.
- ATTACK_START: if `frame_cnt` == `ATK_START_FRAMES`−1 → ATTACK_END, else increment `frame_cnt`. Buttons are ignored.
- ATTACK_END: same rule with `ATK_END_FRAMES`, then → ATTACK_PULL.
- ATTACK_PULL: same rule with `ATK_PULL_FRAMES`, then → IDLE.
- Re-arm: on any tick where `btn_attack` = 0, set `atk_armed` = 1. An attack held through the full sequence therefore does not retrigger until the button is released for at least one tick.
- Motion is applied on the same tick, based on the state held before that tick's transition:
  - FORWARD: `posx` = min(`posx` + `FWD_STEP`, `X_MAX`).
  - BACKWARD: `posx` = `X_MIN` if `posx` < `X_MIN` + `BWD_STEP`, else `posx` − `BWD_STEP`.
  - All other states leave `posx` unchanged.
- Width rule: add and compare in 11 bits so there is no 10-bit wrap. `posx` never leaves [`X_MIN`, `X_MAX`].
- Codes 6..15 are never produced. If `currentstate` is ever corrupted into that range, the next tick goes to IDLE.

## Timing
- Reset values: `currentstate` = 0, `posx` = `START_X`, `posy` = `START_Y`, `attack_active` = 0, `frame_cnt` = 0, `atk_armed` = 1.
- Reset asserted mid-attack or mid-move returns everything to these values immediately, with no clock needed.
- Latency:
  - A button sampled at tick N changes `currentstate` in the cycle after tick N.
  - The first movement step appears after tick N+1.
- All outputs are stable between ticks. `attack_active` is registered alongside `currentstate`, not decoded one cycle late.
- Back-to-back `frame_tick` on consecutive cycles are each honoured as separate frames.
- Occupancy: state S lasts exactly `S_FRAMES` ticks. A full attack lasts 6 + 8 + 6 = 20 ticks with default parameters.

## Test plan
- Reset behaviour: release reset → `currentstate` 0, `posx` 100, `posy` 200, `attack_active` 0. Toggling buttons with no `frame_tick` changes nothing.
- Forward motion: hold `btn_right` for ticks 1..3 → state 1 after tick 1. `posx` reads 100, then 104, then 108 after ticks 1, 2, 3.
- Saturation:
  - From `posx` 488 in FORWARD, the next ticks give 490, then 490.
  - From `posx` 2 in BACKWARD, the next tick gives 0, and it stays 0.
- Attack sequence: press `btn_attack` together with `btn_right` → state 3 for 6 ticks, state 4 (`attack_active` = 1) for 8 ticks, state 5 for 6 ticks, then 0. `posx` is unchanged throughout.
- Attack held continuously: sequence ends in IDLE and does not restart. Release for 1 tick, press again → state 3 on the following tick.
- Reset mid-attack: assert `rst` low during state 4 → state 0 and `posx` 100 asynchronously. After release, holding attack → state 3 on the next tick.
